// File: rtl/inferred_sdp_ram_pkg.sv
// Shared definitions for the inferred simple dual-port RAM:
// sweep FSM state encoding, read-during-write mode constants and the
// byte-lane count helper.
package inferred_sdp_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Number of 8-bit lanes in a word; the word size is a multiple of 8.
  function automatic int byte_lanes(input int word_size);
    return word_size / 8;
  endfunction

endpackage

// File: rtl/inferred_sdp_ram_core.sv
// Pure inferred memory array: byte-enabled synchronous write and a
// registered synchronous read. There is no reset, so synthesis can map the
// array onto block RAM. A read of the address being written in the same
// cycle returns the contents from before the write.
module sdp_ram_core
  import inferred_sdp_ram_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [DEPTH_LOG2-1:0]              waddr,
  input  logic [WORD_SIZE-1:0]               wdata,
  input  logic [byte_lanes(WORD_SIZE)-1:0]   wbe,
  input  logic                               re,
  input  logic [DEPTH_LOG2-1:0]              raddr,
  output logic [WORD_SIZE-1:0]               rdata
);

  localparam int LANES = byte_lanes(WORD_SIZE);

  logic [WORD_SIZE-1:0] mem [2**DEPTH_LOG2];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds the last result while no read is requested.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inferred_sdp_ram.sv
// Simple dual-port RAM top level: post-reset clear sweep with busy flag,
// write-port mux (sweep vs user), same-address read-during-write
// forwarding and an optional extra output register stage.
// Optional feature macro: INFERRED_SDP_RAM_OUT_REG_EN (adds one cycle of
// read latency; rd_valid is delayed with rd_data).
module inferred_sdp_ram
  import inferred_sdp_ram_pkg::*;
#(
  parameter int                   WORD_SIZE   = 32,
  parameter int                   DEPTH_LOG2  = 3,
  parameter int                   RDW_MODE    = RDW_OLD,
  parameter logic [WORD_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [DEPTH_LOG2-1:0]            wr_addr,
  input  logic [WORD_SIZE-1:0]             wr_data,
  input  logic [byte_lanes(WORD_SIZE)-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [DEPTH_LOG2-1:0]            rd_addr,
  output logic [WORD_SIZE-1:0]             rd_data,
  output logic                             rd_valid,
  output logic                             busy
);

  localparam int                    LANES     = byte_lanes(WORD_SIZE);
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DEPTH_LOG2-1:0]   clr_addr_r;
  logic                    run_s;
  logic                    mem_we_s;
  logic [DEPTH_LOG2-1:0]   mem_waddr_s;
  logic [WORD_SIZE-1:0]    mem_wdata_s;
  logic [LANES-1:0]        mem_wbe_s;
  logic                    mem_re_s;
  logic [WORD_SIZE-1:0]    mem_rdata_s;
  logic                    fwd_en_s;
  logic                    valid1_r;
  logic                    zero_r;
  logic [LANES-1:0]        fwd_be_r;
  logic [WORD_SIZE-1:0]    fwd_data_r;
  logic [WORD_SIZE-1:0]    data1_s;

  // Sweep FSM state register; reset restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave CLEAR after the last address has been written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // Sweep address counter; advances once per cycle while clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      clr_addr_r <= clr_addr_r + 1'b1;
    end else begin
      clr_addr_r <= clr_addr_r;
    end
  end

  // User requests count only in RUN and not in a cycle where reset is seen.
  assign run_s    = (state_r == ST_RUN) && !reset;
  assign mem_re_s = run_s && rd_en;
  assign busy     = (state_r == ST_CLEAR);

  // Write-port mux: the sweep owns the port while clearing.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    mem_wbe_s   = wr_be;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r;
      mem_wdata_s = CLEAR_VALUE;
      mem_wbe_s   = '1;
    end else begin
      mem_we_s    = run_s && wr_en;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
      mem_wbe_s   = wr_be;
    end
  end

  sdp_ram_core #(
    .WORD_SIZE  (WORD_SIZE),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_core (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .wbe   (mem_wbe_s),
    .re    (mem_re_s),
    .raddr (rd_addr),
    .rdata (mem_rdata_s)
  );

  // Same-address collision that must return the newly written bytes.
  assign fwd_en_s = (RDW_MODE == RDW_NEW) && mem_re_s && wr_en && (wr_addr == rd_addr);

  // Read-side bookkeeping: valid strobe, post-reset zeroing, forward lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_r   <= 1'b0;
      zero_r     <= 1'b1;
      fwd_be_r   <= '0;
      fwd_data_r <= '0;
    end else begin
      valid1_r <= mem_re_s;
      if (mem_re_s) begin
        zero_r     <= 1'b0;
        fwd_be_r   <= fwd_en_s ? wr_be : '0;
        fwd_data_r <= wr_data;
      end
    end
  end

  // First-stage read word: zero after reset, else per-lane forward/array mux.
  always_comb begin
    data1_s = mem_rdata_s;
    for (int i = 0; i < LANES; i++) begin
      if (zero_r) begin
        data1_s[8*i +: 8] = 8'h00;
      end else if (fwd_be_r[i]) begin
        data1_s[8*i +: 8] = fwd_data_r[8*i +: 8];
      end else begin
        data1_s[8*i +: 8] = mem_rdata_s[8*i +: 8];
      end
    end
  end

`ifdef INFERRED_SDP_RAM_OUT_REG_EN
  logic [WORD_SIZE-1:0] data2_r;
  logic                 valid2_r;

  // Extra output stage: delays data and valid together; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data2_r  <= '0;
      valid2_r <= 1'b0;
    end else begin
      data2_r  <= data1_s;
      valid2_r <= valid1_r;
    end
  end

  assign rd_data  = data2_r;
  assign rd_valid = valid2_r;
`else
  assign rd_data  = data1_s;
  assign rd_valid = valid1_r;
`endif

endmodule

// File: tb/tb_inferred_sdp_ram.sv
// Self-checking bench for inferred_sdp_ram. Two instances share stimulus:
// one with old-data read-during-write and a zero clear value, one with
// new-data forwarding and a non-zero clear value. A word-level reference
// model (memory array, sweep countdown, result pipeline) gives expectations.
module tb_inferred_sdp_ram;

  localparam int          DEPTH = 8;
  localparam logic [31:0] CLR0  = 32'h0000_0000;
  localparam logic [31:0] CLR1  = 32'hA5C3_3C5A;
`ifdef INFERRED_SDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  int          clr_left;
  logic [31:0] s1_d0, s1_d1, s2_d0, s2_d1;
  logic        s1_v, s2_v;

  always #5 clk = ~clk;

  inferred_sdp_ram #(.WORD_SIZE(32), .DEPTH_LOG2(3), .RDW_MODE(0), .CLEAR_VALUE(CLR0)) u_old (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .busy(busy0));

  inferred_sdp_ram #(.WORD_SIZE(32), .DEPTH_LOG2(3), .RDW_MODE(1), .CLEAR_VALUE(CLR1)) u_new (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic e_v();
    return (LAT == 1) ? s1_v : s2_v;
  endfunction
  function automatic logic [31:0] e_d0();
    return (LAT == 1) ? s1_d0 : s2_d0;
  endfunction
  function automatic logic [31:0] e_d1();
    return (LAT == 1) ? s1_d1 : s2_d1;
  endfunction

  // One clock edge: advance the reference model, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clr_left = DEPTH;
      s1_v = 1'b0; s1_d0 = '0; s1_d1 = '0;
      s2_v = 1'b0; s2_d0 = '0; s2_d1 = '0;
      for (int i = 0; i < DEPTH; i++) begin m0[i] = CLR0; m1[i] = CLR1; end
    end else begin
      s2_v = s1_v; s2_d0 = s1_d0; s2_d1 = s1_d1;
      if (clr_left > 0) begin
        clr_left--;
        s1_v = 1'b0;
      end else begin
        if (rd_en) begin
          s1_d0 = m0[rd_addr];
          s1_d1 = (wr_en && wr_addr == rd_addr) ? merge(m1[rd_addr], wr_data, wr_be) : m1[rd_addr];
          s1_v  = 1'b1;
        end else begin
          s1_v = 1'b0;
        end
        if (wr_en) begin
          m0[wr_addr] = merge(m0[wr_addr], wr_data, wr_be);
          m1[wr_addr] = merge(m1[wr_addr], wr_data, wr_be);
        end
      end
    end
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 32'h0; wr_be = 4'h0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL reset_busy: got %b/%b want 1", busy0, busy1);
    end
    n_cmp++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
      n_err++; $display("FAIL reset_out: got v=%b/%b d=%h/%h want 0", rd_valid0, rd_valid1, rd_data0, rd_data1);
    end
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != 8 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL busy_len: got %0d cycles (busy1=%b) want 8", cnt, busy1);
    end
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < DEPTH; a++) begin
      do_read(3'(a));
      n_cmp++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== CLR0 || rd_data1 !== CLR1) begin
        n_err++; $display("FAIL clear_rd[%0d]: got v=%b %h/%h want 1 %h/%h", a, rd_valid0, rd_data0, rd_data1, CLR0, CLR1);
      end
    end
  endtask

  task automatic test_byte_enable();
    do_write(3'd5, 32'hDEAD_BEEF, 4'b1111);
    do_write(3'd5, 32'h0000_00AA, 4'b0001);
    do_write(3'd5, 32'hFFFF_FFFF, 4'b0000);
    do_read(3'd5);
    n_cmp++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hDEAD_BEAA || rd_data1 !== 32'hDEAD_BEAA) begin
      n_err++; $display("FAIL byte_en: got v=%b %h/%h want 1 deadbeaa", rd_valid0, rd_data0, rd_data1);
    end
  endtask

  task automatic test_collision();
    do_write(3'd2, 32'h1111_1111, 4'b1111);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h2222_2222; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 3'd2;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rd_data0 !== 32'h1111_1111 || rd_data1 !== 32'h2222_2222 || rd_valid1 !== 1'b1) begin
      n_err++; $display("FAIL collide_full: got %h/%h want 11111111/22222222", rd_data0, rd_data1);
    end
    do_read(3'd2);
    n_cmp++;
    if (rd_data0 !== 32'h2222_2222 || rd_data1 !== 32'h2222_2222) begin
      n_err++; $display("FAIL after_collide: got %h/%h want 22222222", rd_data0, rd_data1);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h4444_4444; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 3'd2;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    n_cmp++;
    if (rd_data0 !== 32'h2222_2222 || rd_data1 !== 32'h2222_4444) begin
      n_err++; $display("FAIL collide_part: got %h/%h want 22222222/22224444", rd_data0, rd_data1);
    end
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    do_write(3'd3, 32'h1234_5678, 4'b1111);
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || busy0 !== 1'b1) begin
      n_err++; $display("FAIL reset_run: got v=%b d=%h/%h busy=%b want 0 0 1", rd_valid0, rd_data0, rd_data1, busy0);
    end
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hCAFE_F00D; wr_be = 4'b1111;
    rd_addr = 3'd6;
    repeat (4) begin
      tick();
      n_cmp++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
        n_err++; $display("FAIL busy_valid: got %b/%b want 0", rd_valid0, rd_valid1);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != 8) begin
      n_err++; $display("FAIL restart_len: got %0d cycles want 8", cnt);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    do_read(3'd3);
    n_cmp++;
    if (rd_data0 !== CLR0 || rd_data1 !== CLR1) begin
      n_err++; $display("FAIL swept_3: got %h/%h want %h/%h", rd_data0, rd_data1, CLR0, CLR1);
    end
    do_read(3'd6);
    n_cmp++;
    if (rd_data0 !== CLR0 || rd_data1 !== CLR1) begin
      n_err++; $display("FAIL busy_write: got %h/%h want %h/%h", rd_data0, rd_data1, CLR0, CLR1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vv [3];
    logic        v [6];
    logic [31:0] d [6];
    for (int i = 0; i < 3; i++) begin
      vv[i] = $urandom;
      do_write(3'(i), vv[i], 4'b1111);
    end
    for (int i = 0; i < 6; i++) begin
      rd_en = (i < 3); rd_addr = 3'(i);
      tick();
      v[i] = rd_valid0; d[i] = rd_data1;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (v[i] !== ((i >= LAT - 1) && (i <= LAT + 1))) begin
        n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, v[i], ((i >= LAT - 1) && (i <= LAT + 1)));
      end
      if ((i >= LAT - 1) && (i <= LAT + 1)) begin
        n_cmp++;
        if (d[i] !== vv[i - LAT + 1]) begin
          n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d[i], vv[i - LAT + 1]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] val;
    val = $urandom;
    do_write(3'd4, val, 4'b1111);
    do_read(3'd4);
    n_cmp++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== val) begin
      n_err++; $display("FAIL hold_read: got v=%b %h want 1 %h", rd_valid0, rd_data0, val);
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = ~val; wr_be = 4'b1111;
    repeat (3) begin
      rd_addr = 3'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (rd_valid0 !== 1'b0 || rd_data0 !== val || rd_data1 !== val) begin
        n_err++; $display("FAIL hold: got v=%b %h/%h want 0 %h", rd_valid0, rd_data0, rd_data1, val);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      wr_en   = $urandom_range(0, 1);
      rd_en   = $urandom_range(0, 1);
      wr_addr = 3'($urandom_range(0, (n % 2) ? 7 : 3));
      rd_addr = 3'($urandom_range(0, (n % 2) ? 7 : 3));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (busy0 !== (clr_left > 0) || busy1 !== (clr_left > 0)) begin
        n_err++; $display("FAIL rnd_busy@%0d: got %b/%b want %b", n, busy0, busy1, (clr_left > 0));
      end
      n_cmp++;
      if (rd_valid0 !== e_v() || rd_valid1 !== e_v()) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %b/%b want %b", n, rd_valid0, rd_valid1, e_v());
      end
      n_cmp++;
      if (rd_data0 !== e_d0()) begin
        n_err++; $display("FAIL rnd_data_old@%0d: got %h want %h", n, rd_data0, e_d0());
      end
      n_cmp++;
      if (rd_data1 !== e_d1()) begin
        n_err++; $display("FAIL rnd_data_new@%0d: got %h want %h", n, rd_data1, e_d1());
      end
    end
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_collision();
    test_reset_midsweep();
    test_back_to_back();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
